// File: rtl/write_back_arbiter.sv
// write_back_arbiter: two-requester register-file write-port arbiter with ALU starvation guard
module write_back_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] writeData,
    output logic        alu_stall,
    output logic [15:0] conflict_cnt
);
    typedef enum logic {MEM_PRI, ALU_PRI} state_t;
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    state_t      r_state, w_next;
    logic [3:0]  r_starve;
    logic        w_alu_ready, w_mem_ready, w_starved;
    logic        r_reg_write;
    logic [4:0]  r_write_reg;
    logic [31:0] r_write_data;
    logic [15:0] r_conflict;
    assign alu_ready    = w_alu_ready;
    assign mem_ready    = w_mem_ready;
    assign alu_stall    = alu_valid & ~w_alu_ready;
    assign reg_write    = r_reg_write;
    assign write_reg    = r_write_reg;
    assign writeData    = r_write_data;
    assign conflict_cnt = r_conflict;
    // grants are held low during reset; ALU wins ties only once it has been starved
    always_comb begin
        w_alu_ready = rst_n & alu_valid & ((r_state == ALU_PRI) | ~mem_valid);
        w_mem_ready = rst_n & mem_valid & ~w_alu_ready;
        w_starved   = alu_valid & ~w_alu_ready;
        w_next      = r_state;
        if (r_state == MEM_PRI && w_starved && r_starve == LIM - 4'd1)
            w_next = ALU_PRI;
        else if (r_state == ALU_PRI && w_alu_ready)
            w_next = MEM_PRI;
    end
    // priority state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= MEM_PRI;
        else        r_state <= w_next;
    end
    // consecutive-refusal counter for the ALU requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_starve <= 4'd0;
        else if (w_alu_ready)                r_starve <= 4'd0;
        else if (w_starved && r_starve != LIM) r_starve <= r_starve + 4'd1;
    end
    // registered write port; x0 destination is accepted but never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= 5'd0;
            r_write_data <= 32'd0;
        end else begin
            r_reg_write <= (w_alu_ready && alu_rd != 5'd0) || (w_mem_ready && mem_rd != 5'd0);
            if (w_alu_ready) begin
                r_write_reg  <= alu_rd;
                r_write_data <= alu_data;
            end else if (w_mem_ready) begin
                r_write_reg  <= mem_rd;
                r_write_data <= mem_data;
            end
        end
    end
    // saturating count of cycles with both requesters active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         r_conflict <= 16'd0;
        else if (alu_valid && mem_valid && r_conflict != 16'hFFFF) r_conflict <= r_conflict + 16'd1;
    end
endmodule

// File: tb/tb_write_back_arbiter.sv
// tb_write_back_arbiter: scoreboard bench for write_back_arbiter
module tb_write_back_arbiter;
    typedef struct {
        logic [1:0]  g;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] d;
    } rec_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_rd = 5'd0, mem_rd = 5'd0;
    logic [31:0] alu_data = 32'd0, mem_data = 32'd0;
    logic        alu_ready, mem_ready, reg_write, alu_stall;
    logic [4:0]  write_reg;
    logic [31:0] writeData;
    logic [15:0] conflict_cnt;
    int          n_vec = 0, n_err = 0;
    rec_t        q[$];
    rec_t        pr;
    logic        pend = 1'b0;
    localparam logic [1:0] NONE = 2'b00, MEM = 2'b01, ALU = 2'b10;

    write_back_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .reg_write(reg_write), .write_reg(write_reg), .writeData(writeData),
        .alu_stall(alu_stall), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // one stimulus cycle: drive inputs and push the hand-computed response
    task automatic cyc(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic [1:0] g);
        rec_t r;
        @(posedge clk);
        #2;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        mem_valid = mv; mem_rd = mr; mem_data = md;
        r.g  = g;
        r.we = (g == ALU) ? (ar != 5'd0) : (g == MEM) ? (mr != 5'd0) : 1'b0;
        r.rd = (g == ALU) ? ar : mr;
        r.d  = (g == ALU) ? ad : md;
        q.push_back(r);
    endtask

    // monitor: compare grant each cycle, then the write port one edge later
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            chk("excl", 64'(alu_ready & mem_ready), 64'd0);
            if (pend) begin
                if (pr.g != NONE)
                    chk("wb", 64'({reg_write, write_reg, writeData}), 64'({pr.we, pr.rd, pr.d}));
                else
                    chk("idle_we", 64'(reg_write), 64'd0);
            end
            pend = 1'b0;
            if (q.size() != 0) begin
                pr = q.pop_front();
                chk("grant", 64'({alu_ready, mem_ready}), 64'(pr.g));
                chk("stall", 64'(alu_stall), 64'(alu_valid & (pr.g != ALU)));
                pend = 1'b1;
            end
        end
    end

    initial begin
        alu_valid = 1'b1;
        #1;
        chk("rst_out", 64'({reg_write, write_reg, writeData, conflict_cnt}), 64'd0);
        chk("rst_rdy", 64'({alu_ready, mem_ready, alu_stall}), 64'b001);
        alu_valid = 1'b0;
        #11 rst_n = 1'b1;
        cyc(1, 5'd5, 32'd3, 0, 5'd0, 32'd0, ALU);
        cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, NONE);
        for (int k = 0; k < 4; k++)
            cyc(1, 5'd8, 32'd14, 1, 5'd7, 32'd11, (k == 3) ? ALU : MEM);
        cyc(1, 5'd9, 32'd20, 1, 5'd10, 32'd21, MEM);
        chk("conf4", 64'(conflict_cnt), 64'd4);
        cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, NONE);
        chk("conf5", 64'(conflict_cnt), 64'd5);
        cyc(0, 5'd0, 32'd0, 1, 5'd0, 32'd2, MEM);
        cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, NONE);
        cyc(1, 5'd9, 32'h55, 0, 5'd0, 32'd0, ALU);
        cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, NONE);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        alu_valid = 1'b1;
        #1;
        chk("mid_rst", 64'({reg_write, write_reg, writeData, conflict_cnt}), 64'd0);
        chk("mid_rdy", 64'({alu_ready, mem_ready, alu_stall}), 64'b001);
        alu_valid = 1'b0;
        #1 rst_n = 1'b1;
        cyc(1, 5'd6, 32'h21, 0, 5'd0, 32'd0, ALU);
        cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, NONE);
        for (int i = 0; i < 70000; i++)
            cyc(1, 5'd4, 32'hB, 1, 5'd3, 32'hA, (i % 4 == 3) ? ALU : MEM);
        cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, NONE);
        cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, NONE);
        for (int t = 0; t < 10 && q.size() != 0; t++) @(negedge clk);
        chk("drain", 64'(q.size()), 64'd0);
        chk("conf_sat", 64'(conflict_cnt), 64'hFFFF);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
